// File: rtl/wbuf_pkg.sv
// Shared types and defaults for the store write buffer.
package wbuf_pkg;

  localparam int unsigned WBUF_DATA_WIDTH = 32;
  localparam int unsigned WBUF_DEPTH      = 4;

  // Entry field width is fixed by the package; write_buffer's DATA_WIDTH must equal WBUF_DATA_WIDTH.
  typedef struct packed {
    logic [WBUF_DATA_WIDTH-1:0] addr;
    logic [WBUF_DATA_WIDTH-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_match.sv
// Load-address lookup over the buffered entries; returns the newest matching slot.
module wbuf_match
  import wbuf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WBUF_DATA_WIDTH,
  parameter int unsigned DEPTH      = WBUF_DEPTH
) (
  input  logic                         i_ld_valid,
  input  logic [DATA_WIDTH-1:2]        i_ld_tag,
  input  logic [DATA_WIDTH-1:2]        i_tag   [DEPTH],
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [$clog2(DEPTH)-1:0]     i_wr_ptr,
  output logic                         o_hit,
  output logic [$clog2(DEPTH)-1:0]     o_sel
);

  localparam int unsigned PW = $clog2(DEPTH);

  // Walk backwards from wr_ptr-1 so the first hit found is the youngest entry.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    found = 1'b0;
    o_sel = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      idx = i_wr_ptr - PW'(k);
      if (!found && i_ld_valid && i_valid[idx] && (i_tag[idx] == i_ld_tag)) begin
        found = 1'b1;
        o_sel = idx;
      end
    end
    o_hit = found;
  end

endmodule

// File: rtl/write_buffer.sv
// Circular store/write-back buffer draining to data memory, with load lookup.
// Define WBUF_FWD_EN to forward matching store data to loads instead of stalling them.
module write_buffer
  import wbuf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WBUF_DATA_WIDTH,
  parameter int unsigned DEPTH      = WBUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [DATA_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_ready,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_ready,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_addr,
  output logic                  ld_hit,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_stall,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  wbuf_entry_t           r_mem   [DEPTH];

  logic                  w_push;
  logic                  w_pop;
  logic [DEPTH-1:0]      w_valid;
  logic [DATA_WIDTH-1:2] w_tag   [DEPTH];
  logic                  w_hit;
  logic [PW-1:0]         w_sel;
  logic                  w_unused;

  assign full        = (r_count == CW'(DEPTH));
  assign empty       = (r_count == '0);
  assign wb_ready    = !full;
  assign mem_wr_en   = !empty;
  assign mem_addr    = r_mem[r_rd_ptr].addr;
  assign mem_wr_data = r_mem[r_rd_ptr].data;
  assign w_push      = wb_valid && wb_ready;
  assign w_pop       = mem_wr_en && mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the cleared count alone makes stale slots invisible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{addr: wb_addr, data: wb_data};
  end

  // A slot is live when its distance from rd_ptr is below the occupancy count.
  always_comb begin
    logic [PW-1:0] off;
    off = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off        = PW'(i) - r_rd_ptr;
      w_valid[i] = ({1'b0, off} < r_count);
      w_tag[i]   = r_mem[i].addr[DATA_WIDTH-1:2];
    end
  end

  wbuf_match #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_match (
    .i_ld_valid (ld_valid),
    .i_ld_tag   (ld_addr[DATA_WIDTH-1:2]),
    .i_tag      (w_tag),
    .i_valid    (w_valid),
    .i_wr_ptr   (r_wr_ptr),
    .o_hit      (w_hit),
    .o_sel      (w_sel)
  );

`ifdef WBUF_FWD_EN
  assign ld_hit   = w_hit;
  assign ld_data  = w_hit ? r_mem[w_sel].data : '0;
  assign ld_stall = 1'b0;
  assign w_unused = ^ld_addr[1:0];
`else
  assign ld_hit   = 1'b0;
  assign ld_data  = '0;
  assign ld_stall = w_hit;
  assign w_unused = ^{w_sel, ld_addr[1:0]};
`endif

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, address and data width.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state rising-edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port wb_valid, input, 1, cache offers a write-back or store entry.
REQ-006 SHALL have ports wb_addr and wb_data, input, DATA_WIDTH each, the offered entry.
REQ-007 SHALL have port wb_ready, output, 1, buffer accepts the entry this cycle.
REQ-008 SHALL have port mem_wr_en, output, 1, head entry presented to data memory.
REQ-009 SHALL have ports mem_addr and mem_wr_data, output, DATA_WIDTH each, head entry contents.
REQ-010 SHALL have port mem_ready, input, 1, data memory accepts the head write this cycle.
REQ-011 SHALL have port ld_valid, input, 1, a load is being looked up.
REQ-012 SHALL have port ld_addr, input, DATA_WIDTH, load word address.
REQ-013 SHALL have ports ld_hit, output, 1, and ld_data, output, DATA_WIDTH, forwarding result.
REQ-014 SHALL have port ld_stall, output, 1, load must wait for drain.
REQ-015 SHALL have ports empty and full, output, 1 each, occupancy status.

Function
REQ-016 SHALL be a circular FIFO: wr_ptr, rd_ptr of $clog2(DEPTH) bits with wrap to 0; count of $clog2(DEPTH)+1 bits.
REQ-017 SHALL drive wb_ready = !full; no push when full, even with a same-cycle pop.
REQ-018 SHALL push on wb_valid && wb_ready, writing the entry at wr_ptr and incrementing wr_ptr.
REQ-019 SHALL drive mem_wr_en = !empty, with mem_addr and mem_wr_data from entry rd_ptr, combinationally.
REQ-020 SHALL pop on mem_wr_en && mem_ready, incrementing rd_ptr.
REQ-021 SHALL keep count unchanged on simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-022 SHALL give a pushed entry a latency of one cycle: into an empty buffer, mem_wr_en rises the next cycle.
REQ-023 SHALL hold head outputs stable while mem_wr_en && !mem_ready.
REQ-024 SHALL match ld_addr against every valid entry on bits [DATA_WIDTH-1:2]; the entry being pushed this cycle is not matched.
REQ-025 SHALL select the newest matching entry, nearest below wr_ptr in wrap order, when several match.
REQ-026 SHALL drive ld_hit, ld_data and ld_stall low when ld_valid is low or no match exists.
REQ-027 SHALL treat an entry popped this cycle as still valid for matching in that cycle.

Reset
REQ-028 SHALL, on rst, immediately clear pointers and count: empty=1, full=0, wb_ready=1, mem_wr_en=0, ld_hit=0, ld_stall=0.
REQ-029 SHALL discard all pending entries on reset mid-operation; entry storage need not be cleared.

Configuration
REQ-030 SHALL, with WBUF_FWD_EN defined, on a match drive ld_hit=1, ld_data=newest match data, ld_stall=0.
REQ-031 SHALL, without WBUF_FWD_EN, on a match drive ld_stall=1, ld_hit=0, ld_data=0; omit the data mux.

Structure
REQ-032 SHALL place typedef wbuf_entry_t {addr, data} and default DEPTH in shared package wbuf_pkg.
REQ-033 SHALL implement address match and newest-first priority select in sub-module wbuf_match.

Verification
REQ-034 SHALL cover: after reset, push addr 0x100 data 0xAA -> next cycle mem_wr_en=1, mem_addr=0x100; mem_ready=1 -> empty=1.
REQ-035 SHALL cover: mem_ready=0, push 4 entries -> full=1, wb_ready=0; 5th offer is held and not stored; one pop -> wb_ready=1.
REQ-036 SHALL cover: push 0x200/0x11 then 0x200/0x22, ld_addr=0x200 -> with WBUF_FWD_EN ld_hit=1, ld_data=0x22; without it ld_stall=1 until both drain.
REQ-037 SHALL cover: six push/pop cycles at count 2 -> pointers wrap, order preserved, count stays 2.
REQ-038 SHALL cover: rst asserted with 3 entries pending -> mem_wr_en=0 and empty=1 the same cycle; no stale entry emerges after release.
